// File: rtl/uart_alu_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_alu_frame_ctrl
// Description : Collects operand1/operand2/opcode bytes from a UART receiver,
//               strobes the ALU, then serialises the result LSB byte first.
//               Optional inter-byte timeout: define UART_ALU_FRAME_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_alu_frame_ctrl #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int NB_OUT         = 16,
    parameter int TIMEOUT_CYCLES = 5208000
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [7:0]               i_rx_data,
    input  logic                     i_rx_done,
    output logic [NB_DATA-1:0]       o_operand1,
    output logic [NB_DATA-1:0]       o_operand2,
    output logic [NB_OP-1:0]         o_opcode,
    output logic                     o_alu_valid,
    input  logic signed [NB_OUT-1:0] i_result,
    output logic [7:0]               o_tx_data,
    output logic                     o_tx_start,
    input  logic                     i_tx_busy,
    output logic                     o_busy,
    output logic                     o_overrun,
    output logic                     o_timeout
);

    localparam int c_BO    = NB_DATA / 8;
    localparam int c_BR    = NB_OUT / 8;
    localparam int c_CNT_W = (c_BO > 1) ? $clog2(c_BO) : 1;
    localparam int c_TXL_W = $clog2(c_BR + 1);
    localparam logic [c_CNT_W-1:0] c_BO_LAST = c_CNT_W'(c_BO - 1);

    typedef enum logic [2:0] {
        S_RX_OP1  = 3'd0,
        S_RX_OP2  = 3'd1,
        S_RX_OPC  = 3'd2,
        S_EXEC    = 3'd3,
        S_CAPTURE = 3'd4,
        S_TX_SEND = 3'd5,
        S_TX_WAIT = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [c_CNT_W-1:0]   r_byte_cnt;
    logic [c_TXL_W-1:0]   r_tx_left;
    logic [NB_DATA-1:0]   r_op1;
    logic [NB_DATA-1:0]   r_op2;
    logic [NB_OP-1:0]     r_opc;
    logic [NB_OUT-1:0]    r_result;
    logic [7:0]           r_tx_data;
    logic                 w_alu_valid;
    logic                 w_tx_start;
    logic                 w_busy;
    logic                 w_overrun;
    logic                 w_rx_capture;
    logic                 w_timeout;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_RX_OP1;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_alu_valid  = 1'b0;
        w_tx_start   = 1'b0;
        w_busy       = 1'b0;
        w_overrun    = 1'b0;
        w_rx_capture = 1'b0;
        case (r_state)
            S_RX_OP1: begin
                w_rx_capture = i_rx_done;
                if (i_rx_done && (r_byte_cnt == c_BO_LAST)) w_next = S_RX_OP2;
            end
            S_RX_OP2: begin
                w_rx_capture = i_rx_done;
                if (i_rx_done && (r_byte_cnt == c_BO_LAST)) w_next = S_RX_OPC;
            end
            S_RX_OPC: begin
                w_rx_capture = i_rx_done;
                if (i_rx_done) w_next = S_EXEC;
            end
            S_EXEC: begin
                w_alu_valid = 1'b1;
                w_busy      = 1'b1;
                w_overrun   = i_rx_done;
                w_next      = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_busy    = 1'b1;
                w_overrun = i_rx_done;
                w_next    = S_TX_SEND;
            end
            S_TX_SEND: begin
                w_busy    = 1'b1;
                w_overrun = i_rx_done;
                if (!i_tx_busy) begin
                    w_tx_start = 1'b1;
                    w_next     = S_TX_WAIT;
                end
            end
            S_TX_WAIT: begin
                // r_tx_left was already decremented when this byte was started
                w_busy    = 1'b1;
                w_overrun = i_rx_done;
                if (!i_tx_busy) w_next = (r_tx_left != '0) ? S_TX_SEND : S_RX_OP1;
            end
            default: w_next = S_RX_OP1;
        endcase
        if (w_timeout) w_next = S_RX_OP1;
    end

`ifdef UART_ALU_FRAME_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              w_to_active;

    // An empty RX_OP1 is not a partial frame, so it never times out
    assign w_to_active = ((r_state == S_RX_OP1) && (r_byte_cnt != '0)) ||
                         (r_state == S_RX_OP2) || (r_state == S_RX_OPC);
    assign w_timeout   = w_to_active && !i_rx_done && (r_to_cnt == c_TO_LAST);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_to_cnt <= '0;
        end else if (!w_to_active || i_rx_done || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + c_TO_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_byte_cnt <= '0;
            r_tx_left  <= '0;
            r_op1      <= '0;
            r_op2      <= '0;
            r_opc      <= '0;
            r_result   <= '0;
            r_tx_data  <= '0;
        end else begin
            if ((w_next != r_state) || w_timeout) begin
                r_byte_cnt <= '0;
            end else if (w_rx_capture) begin
                r_byte_cnt <= r_byte_cnt + c_CNT_W'(1);
            end

            if (w_rx_capture) begin
                case (r_state)
                    S_RX_OP1: begin
                        for (int b = 0; b < c_BO; b++) begin
                            if (r_byte_cnt == c_CNT_W'(b)) r_op1[b*8 +: 8] <= i_rx_data;
                        end
                    end
                    S_RX_OP2: begin
                        for (int b = 0; b < c_BO; b++) begin
                            if (r_byte_cnt == c_CNT_W'(b)) r_op2[b*8 +: 8] <= i_rx_data;
                        end
                    end
                    S_RX_OPC: r_opc <= i_rx_data[NB_OP-1:0];
                    default: ;
                endcase
            end

            if (r_state == S_CAPTURE) begin
                r_result  <= i_result;
                r_tx_left <= c_TXL_W'(c_BR);
            end

            if (w_tx_start) begin
                r_tx_data <= r_result[7:0];
                r_result  <= r_result >> 8;
                r_tx_left <= r_tx_left - c_TXL_W'(1);
            end
        end
    end

    // The byte on o_tx_data stays visible after the start pulse
    assign o_tx_data   = (r_state == S_TX_SEND) ? r_result[7:0] : r_tx_data;
    assign o_operand1  = r_op1;
    assign o_operand2  = r_op2;
    assign o_opcode    = r_opc;
    assign o_alu_valid = w_alu_valid;
    assign o_tx_start  = w_tx_start;
    assign o_busy      = w_busy;
    assign o_overrun   = w_overrun;
    assign o_timeout   = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_alu_frame_ctrl
// Description : Directed self-checking bench for uart_alu_frame_ctrl (8/16-bit
//               and 16/32-bit instances) with simple ALU and transmitter models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_alu_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [7:0]         a_rx_data;
    logic               a_rx_done;
    logic [7:0]         a_op1;
    logic [7:0]         a_op2;
    logic [5:0]         a_opc;
    logic               a_alu_valid;
    logic signed [15:0] a_result;
    logic [7:0]         a_tx_data;
    logic               a_tx_start;
    logic               a_tx_busy;
    logic               a_busy;
    logic               a_overrun;
    logic               a_timeout;

    logic [7:0]         b_rx_data;
    logic               b_rx_done;
    logic [15:0]        b_op1;
    logic [15:0]        b_op2;
    logic [5:0]         b_opc;
    logic               b_alu_valid;
    logic signed [31:0] b_result;
    logic [7:0]         b_tx_data;
    logic               b_tx_start;
    logic               b_tx_busy;
    logic               b_busy;
    logic               b_overrun;
    logic               b_timeout;

    uart_alu_frame_ctrl #(.NB_DATA(8), .NB_OP(6), .NB_OUT(16), .TIMEOUT_CYCLES(100)) dut_a (
        .i_clk(clk), .i_reset(rst_n), .i_rx_data(a_rx_data), .i_rx_done(a_rx_done),
        .o_operand1(a_op1), .o_operand2(a_op2), .o_opcode(a_opc), .o_alu_valid(a_alu_valid),
        .i_result(a_result), .o_tx_data(a_tx_data), .o_tx_start(a_tx_start),
        .i_tx_busy(a_tx_busy), .o_busy(a_busy), .o_overrun(a_overrun), .o_timeout(a_timeout)
    );

    uart_alu_frame_ctrl #(.NB_DATA(16), .NB_OP(6), .NB_OUT(32), .TIMEOUT_CYCLES(100)) dut_b (
        .i_clk(clk), .i_reset(rst_n), .i_rx_data(b_rx_data), .i_rx_done(b_rx_done),
        .o_operand1(b_op1), .o_operand2(b_op2), .o_opcode(b_opc), .o_alu_valid(b_alu_valid),
        .i_result(b_result), .o_tx_data(b_tx_data), .o_tx_start(b_tx_start),
        .i_tx_busy(b_tx_busy), .o_busy(b_busy), .o_overrun(b_overrun), .o_timeout(b_timeout)
    );

    // ALU models: 0x20 ADD, 0x22 SUB, anything else yields 0
    always_comb begin
        case (a_opc)
            6'h20:   a_result = 16'(a_op1) + 16'(a_op2);
            6'h22:   a_result = 16'(a_op1) - 16'(a_op2);
            default: a_result = '0;
        endcase
    end
    always_comb begin
        case (b_opc)
            6'h20:   b_result = 32'(b_op1) + 32'(b_op2);
            6'h22:   b_result = 32'(b_op1) - 32'(b_op2);
            default: b_result = '0;
        endcase
    end

    // Transmitter models: busy rises the cycle after a start and lasts *_tx_len cycles
    int         a_tx_len = 3;
    int         a_busy_cnt = 0;
    logic       a_start_seen = 1'b0;
    logic [7:0] a_txq[$];
    int         a_valid_cnt = 0;
    int         a_to_cnt = 0;
    int         b_busy_cnt = 0;
    logic       b_start_seen = 1'b0;
    logic [7:0] b_txq[$];

    initial begin
        forever begin
            @(negedge clk);
            if (a_tx_start) begin
                a_txq.push_back(a_tx_data);
                a_start_seen = 1'b1;
            end
            if (b_tx_start) begin
                b_txq.push_back(b_tx_data);
                b_start_seen = 1'b1;
            end
            if (a_alu_valid) a_valid_cnt++;
            if (a_timeout) a_to_cnt++;
        end
    end

    initial begin
        a_tx_busy = 1'b0;
        b_tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (a_start_seen) begin
                a_busy_cnt   = a_tx_len;
                a_start_seen = 1'b0;
            end else if (a_busy_cnt > 0) begin
                a_busy_cnt--;
            end
            if (b_start_seen) begin
                b_busy_cnt   = 2;
                b_start_seen = 1'b0;
            end else if (b_busy_cnt > 0) begin
                b_busy_cnt--;
            end
            a_tx_busy = (a_busy_cnt != 0);
            b_tx_busy = (b_busy_cnt != 0);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_checks++;
        if (obs !== expd) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expd);
        end
    endtask

    // All stimulus tasks start and end 1 time unit after a rising edge
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic a_send(input logic [7:0] b, output logic ovr);
        a_rx_data = b;
        a_rx_done = 1'b1;
        @(negedge clk);
        ovr = a_overrun;
        @(posedge clk);
        #1;
        a_rx_done = 1'b0;
    endtask

    task automatic b_send(input logic [7:0] b);
        b_rx_data = b;
        b_rx_done = 1'b1;
        @(posedge clk);
        #1;
        b_rx_done = 1'b0;
    endtask

    task automatic a_wait_tx(input string tag, input int n);
        int k = 0;
        while (!((a_txq.size() >= n) && !a_busy) && (k < 3000)) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq({tag, "_done"}, 32'((a_txq.size() >= n) && !a_busy), 32'd1);
    endtask

    task automatic a_check_bytes(input string tag, input logic [7:0] e0, input logic [7:0] e1);
        check_eq({tag, "_nbytes"}, 32'(a_txq.size()), 32'd2);
        check_eq({tag, "_byte0"}, (a_txq.size() > 0) ? 32'(a_txq[0]) : 32'hdead, 32'(e0));
        check_eq({tag, "_byte1"}, (a_txq.size() > 1) ? 32'(a_txq[1]) : 32'hdead, 32'(e1));
    endtask

    task automatic a_run_frame(input string tag, input logic [7:0] x, input logic [7:0] y,
                               input logic [7:0] op, input logic [7:0] e0, input logic [7:0] e1);
        logic ovr;
        a_txq.delete();
        a_send(x, ovr);
        a_send(y, ovr);
        a_send(op, ovr);
        a_wait_tx(tag, 2);
        a_check_bytes(tag, e0, e1);
    endtask

    task automatic a_check_reset_outputs(input string tag);
        check_eq({tag, "_data"}, 32'({a_op1, a_op2, a_opc}), 32'd0);
        check_eq({tag, "_ctrl"},
                 32'({a_tx_data, a_alu_valid, a_tx_start, a_busy, a_overrun, a_timeout}), 32'd0);
    endtask

`ifdef UART_ALU_FRAME_TIMEOUT_EN
    localparam int c_EXP_TIMEOUTS = 1;
`else
    localparam int c_EXP_TIMEOUTS = 0;
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed hang, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic ovr;
        int   k;
        int   v0;
        rst_n     = 1'b0;
        a_rx_data = '0;
        a_rx_done = 1'b0;
        b_rx_data = '0;
        b_rx_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        a_check_reset_outputs("por");
        check_eq("por_b", 32'({b_op1, b_busy, b_tx_start, b_alu_valid}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // 16-bit operands, SUB: 0x0100 - 0x0001 = 0x000000FF
        b_txq.delete();
        b_send(8'h00); b_send(8'h01); b_send(8'h01); b_send(8'h00); b_send(8'h22);
        k = 0;
        while (!((b_txq.size() >= 4) && !b_busy) && (k < 3000)) begin
            idle(1);
            k++;
        end
        check_eq("b_sub_done", 32'((b_txq.size() >= 4) && !b_busy), 32'd1);
        check_eq("b_sub_op1", 32'(b_op1), 32'h0100);
        check_eq("b_sub_op2", 32'(b_op2), 32'h0001);
        check_eq("b_sub_bytes", (b_txq.size() == 4) ? {b_txq[3], b_txq[2], b_txq[1], b_txq[0]}
                                                    : 32'hdeadbeef, 32'h000000FF);

        // 8-bit ADD, back-to-back bytes, with latency checks
        a_txq.delete();
        v0 = a_valid_cnt;
        a_send(8'h05, ovr);
        a_send(8'h03, ovr);
        a_send(8'h20, ovr);
        check_eq("add_valid_n1", 32'({a_alu_valid, a_busy}), 32'b11);
        check_eq("add_no_start_n1", 32'(a_tx_start), 32'd0);
        idle(1);
        check_eq("add_valid_n2", 32'(a_alu_valid), 32'd0);
        check_eq("add_no_start_n2", 32'(a_tx_start), 32'd0);
        a_wait_tx("add", 2);
        check_eq("add_ops", 32'({a_op1, a_op2, 2'b00, a_opc}), 32'h050320);
        check_eq("add_valid_count", 32'(a_valid_cnt - v0), 32'd1);
        a_check_bytes("add", 8'h08, 8'h00);

        // Transmitter busy for 500 cycles after the first byte; overrun meanwhile
        a_tx_len = 500;
        a_txq.delete();
        a_send(8'h09, ovr);
        a_send(8'h04, ovr);
        a_send(8'h20, ovr);
        k = 0;
        while ((a_txq.size() < 1) && (k < 50)) begin
            idle(1);
            k++;
        end
        check_eq("hold_first_byte", 32'(a_txq.size()), 32'd1);
        idle(10);
        a_tx_len = 3;
        a_send(8'h55, ovr);
        check_eq("hold_overrun", 32'(ovr), 32'd1);
        check_eq("hold_op1_kept", 32'(a_op1), 32'h09);
        idle(300);
        check_eq("hold_no_second_start", 32'(a_txq.size()), 32'd1);
        a_wait_tx("hold", 2);
        a_check_bytes("hold", 8'h0D, 8'h00);

        // Reset after the first operand byte
        a_txq.delete();
        a_send(8'h11, ovr);
        rst_n = 1'b0;
        @(negedge clk);
        a_check_reset_outputs("rst_rx");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        a_run_frame("rst_rx_frame", 8'h02, 8'h02, 8'h20, 8'h04, 8'h00);

        // Reset while waiting on the transmitter
        a_tx_len = 50;
        a_txq.delete();
        a_send(8'h03, ovr);
        a_send(8'h03, ovr);
        a_send(8'h20, ovr);
        k = 0;
        while ((a_txq.size() < 1) && (k < 50)) begin
            idle(1);
            k++;
        end
        idle(5);
        check_eq("rst_tx_precond", 32'({a_busy, a_tx_data}), 32'h106);
        rst_n = 1'b0;
        @(negedge clk);
        a_check_reset_outputs("rst_tx");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        a_tx_len = 3;
        k = 0;
        while (a_tx_busy && (k < 100)) begin
            idle(1);
            k++;
        end
        a_run_frame("rst_tx_frame", 8'h02, 8'h02, 8'h20, 8'h04, 8'h00);

        // Partial frame followed by a long idle gap
        a_txq.delete();
        a_to_cnt = 0;
        a_send(8'h07, ovr);
        idle(120);
        check_eq("timeout_pulses", 32'(a_to_cnt), 32'(c_EXP_TIMEOUTS));
`ifdef UART_ALU_FRAME_TIMEOUT_EN
        a_run_frame("after_timeout", 8'h01, 8'h01, 8'h20, 8'h02, 8'h00);
        check_eq("after_timeout_op1", 32'(a_op1), 32'h01);
`else
        a_send(8'h01, ovr);
        a_send(8'h01, ovr);
        a_send(8'h20, ovr);
        check_eq("no_timeout_overrun", 32'(ovr), 32'd1);
        check_eq("no_timeout_ops", 32'({a_op1, a_op2, 2'b00, a_opc}), 32'h070101);
        a_wait_tx("no_timeout", 2);
        a_check_bytes("no_timeout", 8'h00, 8'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
